// File: rtl/pcie_ltssm_ctrl.sv
// LTSSM top-level controller: sequences Detect/Polling/Configuration/L0/Recovery substates
// towards the TX and RX sub-blocks and holds the shared link parameters.
module pcie_ltssm_ctrl #(
    parameter int Width          = 32,
    parameter int DEVICETYPE     = 0,
    parameter int GEN1_PIPEWIDTH = 8,
    parameter int GEN2_PIPEWIDTH = 8,
    parameter int GEN3_PIPEWIDTH = 8,
    parameter int GEN4_PIPEWIDTH = 8,
    parameter int GEN5_PIPEWIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] lpifStateRequest,
    input  logic       forceDetect,
    input  logic       finishTx,
    input  logic       finishRx,
    input  logic [3:0] gotoTx,
    input  logic [3:0] gotoRx,
    input  logic [4:0] numberOfDetectedLanesIn,
    input  logic       writeNumberOfDetectedLanes,
    input  logic [7:0] rateIdIn,
    input  logic       writeRateId,
    input  logic       upConfigureCapabilityIn,
    input  logic       writeUpconfigureCapability,
    input  logic [7:0] linkNumberInTx,
    input  logic [7:0] linkNumberInRx,
    input  logic       writeLinkNumberTx,
    input  logic       writeLinkNumberRx,
    output logic [3:0] substateTx,
    output logic [3:0] substateRx,
    output logic [4:0] numberOfDetectedLanesOut,
    output logic [7:0] rateIdOut,
    output logic       upConfigureCapabilityOut,
    output logic [7:0] linkNumberOutTx,
    output logic [7:0] linkNumberOutRx,
    output logic [3:0] lpifStateStatus,
    output logic       linkUp,
    output logic [2:0] GEN,
    output logic [1:0] width
);

    typedef enum logic [3:0] {
        StDetectQuiet       = 4'd0,
        StDetectActive      = 4'd1,
        StPollingActive     = 4'd2,
        StPollingConfig     = 4'd3,
        StCfgLinkWidthStart = 4'd4,
        StCfgLinkWidthAccept= 4'd5,
        StCfgLaneNumWait    = 4'd6,
        StCfgLaneNumAccept  = 4'd7,
        StCfgComplete       = 4'd8,
        StCfgIdle           = 4'd9,
        StL0                = 4'd10,
        StRecRcvrLock       = 4'd11,
        StRecRcvrCfg        = 4'd12,
        StRecIdle           = 4'd13,
        StIdle              = 4'd15
    } substateT;

    substateT   substateQ, substateD;
    substateT   pendingQ, pendingD;
    logic       doneTxQ, doneTxD;
    logic       doneRxQ, doneRxD;
    logic [3:0] gotoTxQ, gotoTxD;
    logic [3:0] gotoRxQ, gotoRxD;
    logic [2:0] genQ, genD;
    logic       linkUpQ, linkUpD;

    logic       needRx;
    logic       advance;
    substateT   target;

    logic [4:0] lanesQ;
    logic [7:0] rateIdQ;
    logic       upCfgQ;
    logic [7:0] linkNumQ;

    int         pipeWidth;

    // Width and DEVICETYPE only matter to the TX/RX sub-blocks.
    logic unusedParams;
    assign unusedParams = (Width == 0) ^ (DEVICETYPE == 0);

    // Highest supported generation advertised in rateId bits 5..1.
    function automatic logic [2:0] highestGen(input logic [4:0] rates);
        if (rates[4])      return 3'd5;
        else if (rates[3]) return 3'd4;
        else if (rates[2]) return 3'd3;
        else if (rates[1]) return 3'd2;
        else               return 3'd1;
    endfunction

    // State register for the substate sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            substateQ <= StDetectQuiet;
            pendingQ  <= StDetectQuiet;
            doneTxQ   <= 1'b0;
            doneRxQ   <= 1'b0;
            gotoTxQ   <= 4'd0;
            gotoRxQ   <= 4'd0;
            genQ      <= 3'd1;
            linkUpQ   <= 1'b0;
        end else begin
            substateQ <= substateD;
            pendingQ  <= pendingD;
            doneTxQ   <= doneTxD;
            doneRxQ   <= doneRxD;
            gotoTxQ   <= gotoTxD;
            gotoRxQ   <= gotoRxD;
            genQ      <= genD;
            linkUpQ   <= linkUpD;
        end
    end

    // Next-state: handshake collection, one-cycle Idle handover, retrain and forced detect.
    always_comb begin
        substateD = substateQ;
        pendingD  = pendingQ;
        doneTxD   = doneTxQ | finishTx;
        doneRxD   = doneRxQ | finishRx;
        gotoTxD   = finishTx ? gotoTx : gotoTxQ;
        gotoRxD   = finishRx ? gotoRx : gotoRxQ;
        genD      = genQ;

        // Detect substates are driven by TX alone.
        needRx  = (substateQ != StDetectQuiet) && (substateQ != StDetectActive);
        advance = doneTxQ && (doneRxQ || !needRx);
        target  = needRx ? substateT'(gotoRxQ) : substateT'(gotoTxQ);

        if (forceDetect) begin
            substateD = StDetectQuiet;
            pendingD  = StDetectQuiet;
            doneTxD   = 1'b0;
            doneRxD   = 1'b0;
            genD      = 3'd1;
        end else if (substateQ == StIdle) begin
            substateD = pendingQ;
        end else if ((substateQ == StL0) && (lpifStateRequest == 4'd2)) begin
            substateD = StIdle;
            pendingD  = StRecRcvrLock;
            doneTxD   = 1'b0;
            doneRxD   = 1'b0;
        end else if (advance) begin
            substateD = StIdle;
            pendingD  = target;
            doneTxD   = 1'b0;
            doneRxD   = 1'b0;
            if ((substateQ == StRecRcvrCfg) && (target == StRecIdle) &&
                (rateIdQ[5:1] != 5'd0)) begin
                genD = highestGen(rateIdQ[5:1]);
            end
        end

        // Idle handover holds the previous link state.
        case (substateD)
            StL0, StRecRcvrLock, StRecRcvrCfg, StRecIdle: linkUpD = 1'b1;
            StIdle:                                       linkUpD = linkUpQ;
            default:                                      linkUpD = 1'b0;
        endcase
    end

    // Outputs: LPIF status decode and PIPE width code for the current generation.
    always_comb begin
        case (substateQ)
            StL0:                                   lpifStateStatus = 4'd1;
            StRecRcvrLock, StRecRcvrCfg, StRecIdle: lpifStateStatus = 4'd2;
            default:                                lpifStateStatus = 4'd0;
        endcase

        case (genQ)
            3'd2:    pipeWidth = GEN2_PIPEWIDTH;
            3'd3:    pipeWidth = GEN3_PIPEWIDTH;
            3'd4:    pipeWidth = GEN4_PIPEWIDTH;
            3'd5:    pipeWidth = GEN5_PIPEWIDTH;
            default: pipeWidth = GEN1_PIPEWIDTH;
        endcase

        if (pipeWidth == 32)      width = 2'd2;
        else if (pipeWidth == 16) width = 2'd1;
        else                      width = 2'd0;
    end

    // Shared link parameters; kept across forced detect, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lanesQ   <= 5'd0;
            rateIdQ  <= 8'd0;
            upCfgQ   <= 1'b0;
            linkNumQ <= 8'd0;
        end else begin
            if (writeNumberOfDetectedLanes) lanesQ  <= numberOfDetectedLanesIn;
            if (writeRateId)                rateIdQ <= rateIdIn;
            if (writeUpconfigureCapability) upCfgQ  <= upConfigureCapabilityIn;
            // RX link number takes precedence on a simultaneous write.
            if (writeLinkNumberRx)      linkNumQ <= linkNumberInRx;
            else if (writeLinkNumberTx) linkNumQ <= linkNumberInTx;
        end
    end

    assign substateTx               = substateQ;
    assign substateRx               = substateQ;
    assign numberOfDetectedLanesOut = lanesQ;
    assign rateIdOut                = rateIdQ;
    assign upConfigureCapabilityOut = upCfgQ;
    assign linkNumberOutTx          = linkNumQ;
    assign linkNumberOutRx          = linkNumQ;
    assign linkUp                   = linkUpQ;
    assign GEN                      = genQ;

endmodule

// File: tb/tb_pcie_ltssm_ctrl.sv
// Scoreboard bench for pcie_ltssm_ctrl: stimulus queues expected values with a due cycle,
// a negedge monitor pops and compares them.
module tb_pcie_ltssm_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] lpifStateRequest;
    logic       forceDetect;
    logic       finishTx, finishRx;
    logic [3:0] gotoTx, gotoRx;
    logic [4:0] numberOfDetectedLanesIn;
    logic       writeNumberOfDetectedLanes;
    logic [7:0] rateIdIn;
    logic       writeRateId;
    logic       upConfigureCapabilityIn;
    logic       writeUpconfigureCapability;
    logic [7:0] linkNumberInTx, linkNumberInRx;
    logic       writeLinkNumberTx, writeLinkNumberRx;
    logic [3:0] substateTx, substateRx;
    logic [4:0] numberOfDetectedLanesOut;
    logic [7:0] rateIdOut;
    logic       upConfigureCapabilityOut;
    logic [7:0] linkNumberOutTx, linkNumberOutRx;
    logic [3:0] lpifStateStatus;
    logic       linkUp;
    logic [2:0] GEN;
    logic [1:0] width;

    localparam int SelSubTx  = 0;
    localparam int SelSubRx  = 1;
    localparam int SelStatus = 2;
    localparam int SelLinkUp = 3;
    localparam int SelGen    = 4;
    localparam int SelWidth  = 5;
    localparam int SelLnTx   = 6;
    localparam int SelLnRx   = 7;
    localparam int SelLanes  = 8;
    localparam int SelRate   = 9;
    localparam int SelUpCfg  = 10;

    typedef struct {
        int    due;
        int    sel;
        int    exp;
        string name;
    } expT;

    expT sb[$];
    int  cyc    = 0;
    int  errors = 0;
    int  checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pcie_ltssm_ctrl #(
        .Width          (32),
        .DEVICETYPE     (0),
        .GEN1_PIPEWIDTH (8),
        .GEN2_PIPEWIDTH (16),
        .GEN3_PIPEWIDTH (32),
        .GEN4_PIPEWIDTH (32),
        .GEN5_PIPEWIDTH (32)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .lpifStateRequest           (lpifStateRequest),
        .forceDetect                (forceDetect),
        .finishTx                   (finishTx),
        .finishRx                   (finishRx),
        .gotoTx                     (gotoTx),
        .gotoRx                     (gotoRx),
        .numberOfDetectedLanesIn    (numberOfDetectedLanesIn),
        .writeNumberOfDetectedLanes (writeNumberOfDetectedLanes),
        .rateIdIn                   (rateIdIn),
        .writeRateId                (writeRateId),
        .upConfigureCapabilityIn    (upConfigureCapabilityIn),
        .writeUpconfigureCapability (writeUpconfigureCapability),
        .linkNumberInTx             (linkNumberInTx),
        .linkNumberInRx             (linkNumberInRx),
        .writeLinkNumberTx          (writeLinkNumberTx),
        .writeLinkNumberRx          (writeLinkNumberRx),
        .substateTx                 (substateTx),
        .substateRx                 (substateRx),
        .numberOfDetectedLanesOut   (numberOfDetectedLanesOut),
        .rateIdOut                  (rateIdOut),
        .upConfigureCapabilityOut   (upConfigureCapabilityOut),
        .linkNumberOutTx            (linkNumberOutTx),
        .linkNumberOutRx            (linkNumberOutRx),
        .lpifStateStatus            (lpifStateStatus),
        .linkUp                     (linkUp),
        .GEN                        (GEN),
        .width                      (width)
    );

    function automatic int sigVal(input int sel);
        case (sel)
            SelSubTx:  return int'(substateTx);
            SelSubRx:  return int'(substateRx);
            SelStatus: return int'(lpifStateStatus);
            SelLinkUp: return int'(linkUp);
            SelGen:    return int'(GEN);
            SelWidth:  return int'(width);
            SelLnTx:   return int'(linkNumberOutTx);
            SelLnRx:   return int'(linkNumberOutRx);
            SelLanes:  return int'(numberOfDetectedLanesOut);
            SelRate:   return int'(rateIdOut);
            default:   return int'(upConfigureCapabilityOut);
        endcase
    endfunction

    // Monitor: compare every expectation that has come due this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                checks++;
                if ((sb[i].due < cyc) || (sigVal(sb[i].sel) != sb[i].exp)) begin
                    errors++;
                    $display("FAIL %s: got %0d want %0d (cycle %0d)", sb[i].name,
                             sigVal(sb[i].sel), sb[i].exp, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectAt(input string name, input int sel, input int exp, input int dly);
        expT e;
        e.due  = cyc + dly;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic expectSub(input int exp, input int dly);
        expectAt("substateTx", SelSubTx, exp, dly);
        expectAt("substateRx", SelSubRx, exp, dly);
    endtask

    task automatic finishes(input logic fTx, input logic [3:0] gTx,
                            input logic fRx, input logic [3:0] gRx);
        finishTx = fTx;
        gotoTx   = gTx;
        finishRx = fRx;
        gotoRx   = gRx;
        tick();
        finishTx = 1'b0;
        finishRx = 1'b0;
    endtask

    // Drive the finish pulses and expect: old substate, one Idle cycle, then the target.
    task automatic hop(input logic fTx, input logic [3:0] gTx, input logic fRx,
                       input logic [3:0] gRx, input int from, input int to);
        expectSub(from, 1);
        expectSub(15, 2);
        expectSub(to, 3);
        finishes(fTx, gTx, fRx, gRx);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got running want finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        lpifStateRequest = 4'd1;
        forceDetect = 1'b0;
        finishTx = 1'b0;
        finishRx = 1'b0;
        gotoTx = 4'd0;
        gotoRx = 4'd0;
        numberOfDetectedLanesIn = 5'd0;
        writeNumberOfDetectedLanes = 1'b0;
        rateIdIn = 8'd0;
        writeRateId = 1'b0;
        upConfigureCapabilityIn = 1'b0;
        writeUpconfigureCapability = 1'b0;
        linkNumberInTx = 8'd0;
        linkNumberInRx = 8'd0;
        writeLinkNumberTx = 1'b0;
        writeLinkNumberRx = 1'b0;
        tick();
        tick();
        tick();

        // Reset state
        checks++;
        if (substateTx !== 4'd0 || substateRx !== 4'd0) begin
            errors++;
            $display("FAIL direct reset substate: got %0d/%0d want 0", substateTx, substateRx);
        end
        checks++;
        if (GEN !== 3'd1) begin
            errors++;
            $display("FAIL direct reset GEN: got %0d want 1", GEN);
        end
        expectSub(0, 0);
        expectAt("reset status", SelStatus, 0, 0);
        expectAt("reset linkUp", SelLinkUp, 0, 0);
        expectAt("reset GEN", SelGen, 1, 0);
        expectAt("reset width", SelWidth, 0, 0);
        expectAt("reset linkNum", SelLnTx, 0, 0);
        expectAt("reset lanes", SelLanes, 0, 0);
        tick();
        reset = 1'b0;
        tick();

        // Detect: TX alone advances
        hop(1'b1, 4'd1, 1'b0, 4'd0, 0, 1);
        hop(1'b1, 4'd2, 1'b0, 4'd0, 1, 2);

        // PollingActive: TX done, RX four cycles later; no advance until RX
        expectSub(2, 1);
        expectSub(2, 2);
        expectSub(2, 3);
        expectSub(2, 4);
        finishes(1'b1, 4'd3, 1'b0, 4'd0);
        tick();
        tick();
        tick();
        hop(1'b0, 4'd0, 1'b1, 4'd3, 2, 3);
        expectAt("polling status", SelStatus, 0, 0);
        expectAt("polling linkUp", SelLinkUp, 0, 0);

        // Configuration; the first hop has differing gotos and RX must win
        hop(1'b1, 4'd5, 1'b1, 4'd4, 3, 4);
        hop(1'b1, 4'd5, 1'b1, 4'd5, 4, 5);
        hop(1'b1, 4'd6, 1'b1, 4'd6, 5, 6);
        hop(1'b1, 4'd7, 1'b1, 4'd7, 6, 7);
        hop(1'b1, 4'd8, 1'b1, 4'd8, 7, 8);
        hop(1'b1, 4'd9, 1'b1, 4'd9, 8, 9);

        // Enter L0; Idle handover keeps linkUp low
        expectAt("handover linkUp", SelLinkUp, 0, 2);
        expectAt("handover status", SelStatus, 0, 2);
        hop(1'b1, 4'd10, 1'b1, 4'd10, 9, 10);
        expectAt("L0 status", SelStatus, 1, 0);
        expectAt("L0 linkUp", SelLinkUp, 1, 0);
        checks++;
        if (lpifStateStatus !== 4'd1 || linkUp !== 1'b1) begin
            errors++;
            $display("FAIL direct L0: got status %0d linkUp %0d want 1/1", lpifStateStatus,
                     linkUp);
        end

        // Register writes; simultaneous link number writes, RX wins
        expectAt("linkNum before write", SelLnTx, 0, 0);
        linkNumberInTx = 8'h05;
        linkNumberInRx = 8'h07;
        writeLinkNumberTx = 1'b1;
        writeLinkNumberRx = 1'b1;
        numberOfDetectedLanesIn = 5'd16;
        writeNumberOfDetectedLanes = 1'b1;
        rateIdIn = 8'h06;
        writeRateId = 1'b1;
        upConfigureCapabilityIn = 1'b1;
        writeUpconfigureCapability = 1'b1;
        expectAt("linkNumberOutTx", SelLnTx, 8'h07, 1);
        expectAt("linkNumberOutRx", SelLnRx, 8'h07, 1);
        expectAt("lanes", SelLanes, 16, 1);
        expectAt("rateId", SelRate, 8'h06, 1);
        expectAt("upConfigure", SelUpCfg, 1, 1);
        tick();
        checks++;
        if (linkNumberOutRx !== 8'h07) begin
            errors++;
            $display("FAIL direct linkNumberOutRx: got %0d want 7", linkNumberOutRx);
        end
        writeLinkNumberTx = 1'b0;
        writeLinkNumberRx = 1'b0;
        writeNumberOfDetectedLanes = 1'b0;
        writeRateId = 1'b0;
        writeUpconfigureCapability = 1'b0;
        tick();

        // Lone TX finish in L0 must not advance and is discarded by the retrain
        expectSub(10, 1);
        finishes(1'b1, 4'd0, 1'b0, 4'd0);
        lpifStateRequest = 4'd2;
        expectSub(15, 1);
        expectAt("retrain handover linkUp", SelLinkUp, 1, 1);
        expectSub(11, 2);
        expectAt("recovery status", SelStatus, 2, 2);
        expectAt("recovery linkUp", SelLinkUp, 1, 2);
        tick();
        lpifStateRequest = 4'd1;
        tick();

        // Only RX in RecRcvrLock: stale TX flag must be gone, so no advance
        expectSub(11, 1);
        expectSub(11, 2);
        expectSub(11, 3);
        finishes(1'b0, 4'd0, 1'b1, 4'd12);
        tick();
        hop(1'b1, 4'd12, 1'b0, 4'd0, 11, 12);

        // RecRcvrCfg -> RecIdle with rateId 0x06 selects Gen2 (16-bit PIPE)
        expectAt("GEN before update", SelGen, 1, 1);
        expectAt("GEN after update", SelGen, 2, 2);
        expectAt("width at Gen2", SelWidth, 1, 3);
        hop(1'b1, 4'd13, 1'b1, 4'd13, 12, 13);
        expectAt("RecIdle status", SelStatus, 2, 0);
        hop(1'b1, 4'd10, 1'b1, 4'd10, 13, 10);
        expectAt("back to L0 status", SelStatus, 1, 0);

        // forceDetect from L0
        forceDetect = 1'b1;
        expectSub(0, 1);
        expectAt("force linkUp", SelLinkUp, 0, 1);
        expectAt("force GEN", SelGen, 1, 1);
        expectAt("force width", SelWidth, 0, 1);
        expectAt("force status", SelStatus, 0, 1);
        expectAt("force keeps linkNum", SelLnRx, 8'h07, 1);
        expectAt("force keeps lanes", SelLanes, 16, 1);
        tick();
        checks++;
        if (substateTx !== 4'd0 || GEN !== 3'd1) begin
            errors++;
            $display("FAIL direct forceDetect: got substate %0d GEN %0d want 0/1", substateTx,
                     GEN);
        end
        checks++;
        if (linkNumberOutTx !== 8'h07) begin
            errors++;
            $display("FAIL direct force keeps linkNum: got %0d want 7", linkNumberOutTx);
        end
        forceDetect = 1'b0;
        tick();

        // Jump straight into Recovery, then reset mid-Recovery
        hop(1'b1, 4'd11, 1'b0, 4'd0, 0, 11);
        expectAt("jump linkUp", SelLinkUp, 1, 0);
        expectAt("jump status", SelStatus, 2, 0);
        reset = 1'b1;
        expectSub(0, 1);
        expectAt("mid reset linkUp", SelLinkUp, 0, 1);
        expectAt("mid reset status", SelStatus, 0, 1);
        expectAt("mid reset GEN", SelGen, 1, 1);
        expectAt("mid reset linkNum", SelLnTx, 0, 1);
        expectAt("mid reset lanes", SelLanes, 0, 1);
        expectAt("mid reset rateId", SelRate, 0, 1);
        expectAt("mid reset upConfigure", SelUpCfg, 0, 1);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        if (errors != 0) $display("FAIL summary: got %0d errors want 0", errors);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcie_ltssm_ctrl.md
Name: pcie_ltssm_ctrl

Overview:
- Top-level LTSSM controller of the PCIe PHY. Sequences the link through Detect, Polling, Configuration, L0 and Recovery by issuing substates to the TX and RX sub-blocks and collecting their finish/goto handshakes.
- Holds the shared link parameters (detected lanes, link number, rate ID, upconfigure capability).
- Reports LPIF state status, linkUp, current generation and PIPE width.

Parameters:
- Width, 32, maximum PIPE data width per lane (informational).
- DEVICETYPE, 0, 0 = downstream port, 1 = upstream port.
- GEN1_PIPEWIDTH … GEN5_PIPEWIDTH, 8 each, PIPE width (8/16/32) used at each generation.

Ports:
- clk  in  1  PIPE clock.
- reset  in  1  synchronous, active-high.
- lpifStateRequest  in  4  LPIF request: 0 = Reset, 1 = Active, 2 = Retrain.
- forceDetect  in  1  force the link back to Detect.
- finishTx / finishRx  in  1  one-cycle done pulse from TX / RX.
- gotoTx / gotoRx  in  4  next substate requested by TX / RX, valid with the finish pulse.
- numberOfDetectedLanesIn  in  5  lane count from TX.
- writeNumberOfDetectedLanes  in  1  write strobe for the lane count.
- rateIdIn  in  8  rate ID from RX.
- writeRateId  in  1  write strobe for the rate ID.
- upConfigureCapabilityIn  in  1  upconfigure capability from RX.
- writeUpconfigureCapability  in  1  write strobe for the upconfigure capability.
- linkNumberInTx / linkNumberInRx  in  8  link number from TX / RX.
- writeLinkNumberTx / writeLinkNumberRx  in  1  write strobes for the link number.
- substateTx / substateRx  out  4  substate commanded to TX / RX.
- numberOfDetectedLanesOut  out  5  stored lane count.
- rateIdOut  out  8  stored rate ID.
- upConfigureCapabilityOut  out  1  stored upconfigure capability.
- linkNumberOutTx / linkNumberOutRx  out  8  stored link number (same register on both ports).
- lpifStateStatus  out  4  0 = Reset, 1 = Active, 2 = Retrain.
- linkUp  out  1  link trained.
- GEN  out  3  current generation, 1..5.
- width  out  2  PIPE width code: 0 = 8b, 1 = 16b, 2 = 32b.

Behaviour:
- Substate codes:
  - 0 DetectQuiet, 1 DetectActive
  - 2 PollingActive, 3 PollingConfig
  - 4 CfgLinkWidthStart, 5 CfgLinkWidthAccept, 6 CfgLaneNumWait, 7 CfgLaneNumAccept, 8 CfgComplete, 9 CfgIdle
  - 10 L0
  - 11 RecRcvrLock, 12 RecRcvrCfg, 13 RecIdle
  - 15 Idle (handover)
- Reset values:
  - substate registers, substateTx and substateRx = 0 (DetectQuiet)
  - all stored registers = 0
  - GEN = 1, linkUp = 0, lpifStateStatus = 0
  - done flags cleared
- Handshake:
  - finishTx latches doneTx together with gotoTx; finishRx latches doneRx together with gotoRx.
  - In DetectQuiet and DetectActive only doneTx is required to advance. In all other substates both doneTx and doneRx are required.
- Transition:
  - When the required done flags are set, target = gotoRx if doneRx was required, otherwise gotoTx.
  - Clear the flags and drive 15 on substateTx and substateRx for exactly one cycle. On the next cycle drive the target on both ports.
  - Simultaneous finishTx and finishRx in the same cycle count as both done.
- L0:
  - lpifStateRequest == 2 for one cycle → enter RecRcvrLock through the same 1-cycle Idle handover.
  - Outstanding done flags are discarded.
- forceDetect:
  - Highest priority after reset.
  - Next cycle: substates = 0, flags cleared, linkUp = 0, GEN = 1. Stored registers are kept.
- Status:
  - lpifStateStatus = 1 in L0; = 2 in Recovery substates 11–13; = 0 otherwise.
  - linkUp = 1 in substates 10–13; = 0 otherwise. Idle code 15 keeps the previous linkUp value.
- Register writes:
  - Each register updates on the cycle after its strobe.
  - Link number: if writeLinkNumberTx and writeLinkNumberRx are both high, the Rx value wins.
- GEN update:
  - On the RecRcvrCfg → RecIdle transition, GEN = index of the highest set bit in rateIdOut[5:1] (bit1 = Gen1 … bit5 = Gen5).
  - If no bit in rateIdOut[5:1] is set, GEN is unchanged.
- width: combinational from GEN via the matching GENx_PIPEWIDTH parameter (8 → 0, 16 → 1, 32 → 2).
- DEVICETYPE does not change sequencing; it is passed to the TX and RX sub-blocks only.

Test Plan:
- Reset → substateTx = substateRx = 0, lpifStateStatus = 0, linkUp = 0, GEN = 1, width = 0.
- In DetectQuiet: finishTx pulse with gotoTx = 1 and no finishRx → one cycle of substate 15, then substate 1.
- In PollingActive: finishTx with gotoTx = 3, then finishRx with gotoRx = 3 four cycles later → no advance until finishRx; substate 3 two cycles after finishRx.
- Walk through to L0 → lpifStateStatus = 1, linkUp = 1. Then request lpifStateRequest = 2 → substate 11, status = 2. Recovery finish to RecIdle with rateIdOut = 8'h06 → GEN = 2.
- writeLinkNumberTx = 1 (value 8'h05) and writeLinkNumberRx = 1 (value 8'h07) in the same cycle → linkNumberOutTx = linkNumberOutRx = 8'h07. A writeNumberOfDetectedLanes strobe with 16 → numberOfDetectedLanesOut = 16.
- In L0: assert forceDetect → next cycle substate 0, linkUp = 0, GEN = 1, link number retained. Reset asserted mid-Recovery → all reset values on the next cycle.
